// File: rtl/gray_sum_convert.sv
// Grayscale sum/convert stage: aligns three weighted float terms,
// adds them and rounds the sum to a saturated pixel value.
`timescale 1ns/1ps
module gray_sum_convert #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8,
    parameter int SUM_WIDTH      = 26,
    parameter int MAX_ALIGN      = 26
) (
    input  logic                     clk_i_gray,
    input  logic                     rstn_i_gray,
    input  logic                     en_i_gray,
    input  logic [MANTISSA_WIDTH:0]  mant_i_R,
    input  logic [MANTISSA_WIDTH:0]  mant_i_G,
    input  logic [MANTISSA_WIDTH:0]  mant_i_B,
    input  logic [EXP_WIDTH-1:0]     exp_i_R,
    input  logic [EXP_WIDTH-1:0]     exp_i_G,
    input  logic [EXP_WIDTH-1:0]     exp_i_B,
    output logic [PIXEL_WIDTH-1:0]   gray_o,
    output logic                     gray_valid_o,
    output logic                     busy_o
);
    localparam int MW = MANTISSA_WIDTH + 1;
    localparam int DW = $clog2(MAX_ALIGN + 1);
    localparam int SW = $clog2(SUM_WIDTH);
    localparam logic signed [EXP_WIDTH:0]   LIM_X   = (EXP_WIDTH+1)'(MAX_ALIGN);
    localparam logic [DW-1:0]               LIM_D   = DW'(MAX_ALIGN);
    localparam logic signed [EXP_WIDTH-1:0] E_SAT   = EXP_WIDTH'(PIXEL_WIDTH);
    localparam logic signed [EXP_WIDTH-1:0] E_ZERO  = EXP_WIDTH'(-3);
    localparam logic [SW-1:0]               SH_BASE = SW'(MANTISSA_WIDTH - 1);
    localparam logic [SUM_WIDTH-1:0]        PIX_MAX = SUM_WIDTH'(2**PIXEL_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_CONV  = 3'd4;

    logic [2:0]                  r_state;
    logic [MW-1:0]               r_mant [3];
    logic signed [EXP_WIDTH-1:0] r_exp  [3];
    logic [DW-1:0]               r_d    [3];
    logic [DW-1:0]               r_cnt;
    logic signed [EXP_WIDTH-1:0] r_emax;
    logic                        r_zero;
    logic [SUM_WIDTH-1:0]        r_sum;
    logic [PIXEL_WIDTH-1:0]      r_gray;
    logic                        r_valid;

    logic signed [EXP_WIDTH-1:0] w_emax;
    logic                        w_any;
    logic [DW-1:0]               w_d [3];
    logic [DW-1:0]               w_n;
    logic [SUM_WIDTH-1:0]        w_sum;
    logic [SW-1:0]               w_sh;
    logic [SUM_WIDTH-1:0]        w_x2;
    logic [SUM_WIDTH-1:0]        w_g;
    logic [PIXEL_WIDTH-1:0]      w_gray;

    // Zero-mantissa channels take no part in picking the common exponent
    always_comb begin
        logic signed [EXP_WIDTH:0] v_diff;
        w_emax = '0;
        w_any  = 1'b0;
        w_n    = '0;
        v_diff = '0;
        for (int c = 0; c < 3; c++) begin
            if (r_mant[c] != '0 && (!w_any || r_exp[c] > w_emax)) begin
                w_emax = r_exp[c];
                w_any  = 1'b1;
            end
        end
        for (int c = 0; c < 3; c++) begin
            v_diff = {w_emax[EXP_WIDTH-1], w_emax}
                   - {r_exp[c][EXP_WIDTH-1], r_exp[c]};
            w_d[c] = '0;
            if (r_mant[c] != '0)
                w_d[c] = (v_diff > LIM_X) ? LIM_D : v_diff[DW-1:0];
            if (w_d[c] > w_n)
                w_n = w_d[c];
        end
    end

    assign w_sum = SUM_WIDTH'(r_mant[0]) + SUM_WIDTH'(r_mant[1])
                 + SUM_WIDTH'(r_mant[2]);

    // Outside -2..7 the result saturates, so only right shifts remain
    assign w_sh = SH_BASE - SW'(r_emax);
    assign w_x2 = r_sum >> w_sh;
    assign w_g  = SUM_WIDTH'(({1'b0, w_x2} + 1'b1) >> 1);

    always_comb begin
        w_gray = w_g[PIXEL_WIDTH-1:0];
        if (r_zero)
            w_gray = '0;
        else if (r_emax >= E_SAT)
            w_gray = '1;
        else if (r_emax <= E_ZERO)
            w_gray = '0;
        else if (w_g > PIX_MAX)
            w_gray = '1;
    end

    always_ff @(posedge clk_i_gray or negedge rstn_i_gray) begin
        if (!rstn_i_gray) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_emax  <= '0;
            r_zero  <= 1'b0;
            r_sum   <= '0;
            r_gray  <= '0;
            r_valid <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                r_mant[c] <= '0;
                r_exp[c]  <= '0;
                r_d[c]    <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (en_i_gray) begin
                        r_mant[0] <= mant_i_R;
                        r_mant[1] <= mant_i_G;
                        r_mant[2] <= mant_i_B;
                        r_exp[0]  <= exp_i_R;
                        r_exp[1]  <= exp_i_G;
                        r_exp[2]  <= exp_i_B;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_emax <= w_emax;
                    r_zero <= !w_any;
                    r_cnt  <= w_n;
                    for (int c = 0; c < 3; c++)
                        r_d[c] <= w_d[c];
                    r_state <= (w_n == '0) ? S_ADD : S_ALIGN;
                end
                S_ALIGN: begin
                    for (int c = 0; c < 3; c++) begin
                        if (r_d[c] != '0) begin
                            r_mant[c] <= r_mant[c] >> 1;
                            r_d[c]    <= r_d[c] - 1'b1;
                        end
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == DW'(1))
                        r_state <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= w_sum;
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    r_gray  <= w_gray;
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gray_o       = r_gray;
    assign gray_valid_o = r_valid;
    assign busy_o       = (r_state != S_IDLE);

endmodule
